// File: rtl/rpsc_annunciator.sv
// rpsc_annunciator: 8-channel ringback annunciator with per-channel alert FSMs,
// flash timing, horn drive and first-out capture.
module rpsc_annunciator #(
    parameter int FAST_HALF = 12500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] alarm_in,
    input  logic       emergency_in,
    input  logic       ack_pb,
    input  logic       reset_pb,
    input  logic       lamp_test,
    output logic [7:0] lamp,
    output logic       emergency_lamp,
    output logic       horn,
    output logic [2:0] first_out,
    output logic       first_out_valid
);
    localparam int CW = $clog2(FAST_HALF);
    localparam logic [CW-1:0] CNT_MAX = CW'(FAST_HALF - 1);
    localparam logic [1:0] S_NORMAL = 2'd0;
    localparam logic [1:0] S_ALERT  = 2'd1;
    localparam logic [1:0] S_ACKED  = 2'd2;
    localparam logic [1:0] S_RTN    = 2'd3;

    logic [7:0]    r_alarm_q;
    logic          r_emerg_q;
    logic          r_ack_q;
    logic          r_rst_q;
    logic          r_lt_q;
    logic          r_ack_prev;
    logic          r_rst_prev;
    logic          r_armed;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_div;
    logic          r_fast;
    logic          r_slow;
    logic [1:0]    r_state [8];
    logic [2:0]    r_first_out;
    logic          r_first_valid;

    logic          w_ack_edge;
    logic          w_rst_edge;
    logic          w_wrap;
    logic [1:0]    w_next [8];
    logic [7:0]    w_enter;
    logic [7:0]    w_is_alert;
    logic [7:0]    w_is_normal;
    logic [7:0]    w_next_normal;
    logic [7:0]    w_lamp;
    logic [2:0]    w_first_idx;
    logic          w_all_normal;

    assign w_ack_edge   = r_ack_q & ~r_ack_prev;
    assign w_rst_edge   = r_rst_q & ~r_rst_prev;
    assign w_wrap       = (r_cnt == CNT_MAX);
    assign w_all_normal = &w_is_normal;

    for (genvar n = 0; n < 8; n++) begin : g_ch
        assign w_next[n] = (r_state[n] == S_NORMAL) ? (r_alarm_q[n] ? S_ALERT : S_NORMAL) :
                           (r_state[n] == S_ALERT)  ? (w_ack_edge ? (r_alarm_q[n] ? S_ACKED : S_NORMAL) : S_ALERT) :
                           (r_state[n] == S_ACKED)  ? (r_alarm_q[n] ? S_ACKED : S_RTN) :
                           (r_alarm_q[n] ? S_ALERT : (w_rst_edge ? S_NORMAL : S_RTN));
        assign w_is_alert[n]    = (r_state[n] == S_ALERT);
        assign w_is_normal[n]   = (r_state[n] == S_NORMAL);
        assign w_next_normal[n] = (w_next[n] == S_NORMAL);
        assign w_enter[n]       = w_is_normal[n] & (w_next[n] == S_ALERT);
        assign w_lamp[n]        = (r_state[n] == S_ALERT) ? r_fast :
                                  (r_state[n] == S_ACKED) ? 1'b1 :
                                  (r_state[n] == S_RTN)   ? r_slow : 1'b0;
    end

    always_comb begin
        w_first_idx = 3'd0;
        for (int i = 7; i >= 0; i--) if (w_enter[i]) w_first_idx = 3'(i);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_alarm_q     <= '0;
            r_emerg_q     <= 1'b0;
            r_ack_q       <= 1'b0;
            r_rst_q       <= 1'b0;
            r_lt_q        <= 1'b0;
            r_ack_prev    <= 1'b1;
            r_rst_prev    <= 1'b1;
            r_armed       <= 1'b0;
            r_cnt         <= '0;
            r_div         <= '0;
            r_fast        <= 1'b1;
            r_slow        <= 1'b1;
            r_first_out   <= '0;
            r_first_valid <= 1'b0;
            for (int i = 0; i < 8; i++) r_state[i] <= S_NORMAL;
        end else begin
            r_alarm_q  <= alarm_in;
            r_emerg_q  <= emergency_in;
            r_ack_q    <= ack_pb;
            r_rst_q    <= reset_pb;
            r_lt_q     <= lamp_test;
            // the first post-reset sample still holds the reset value, so keep treating buttons as held
            r_ack_prev <= r_armed ? r_ack_q : 1'b1;
            r_rst_prev <= r_armed ? r_rst_q : 1'b1;
            r_armed    <= 1'b1;
            r_cnt      <= w_wrap ? '0 : r_cnt + 1'b1;
            if (w_wrap) begin
                r_fast <= ~r_fast;
                r_div  <= r_div + 2'd1;
                if (r_div == 2'd3) r_slow <= ~r_slow;
            end
            for (int i = 0; i < 8; i++) r_state[i] <= w_next[i];
            if (w_all_normal && |w_enter) begin
                r_first_out   <= w_first_idx;
                r_first_valid <= 1'b1;
            end else if (&w_next_normal) begin
                r_first_out   <= '0;
                r_first_valid <= 1'b0;
            end
        end
    end

    assign lamp            = r_lt_q ? 8'hFF : w_lamp;
    assign emergency_lamp  = r_emerg_q | r_lt_q;
    assign horn            = (|w_is_alert) | r_emerg_q;
    assign first_out       = r_first_out;
    assign first_out_valid = r_first_valid;
endmodule

// File: tb/tb_rpsc_annunciator.sv
// tb_rpsc_annunciator: directed scenarios plus randomized traffic checked every
// cycle against a behavioural annunciator model.
module tb_rpsc_annunciator;
    localparam int FH = 4;
    localparam int NORMAL = 0, ALERT = 1, ACKED = 2, RTN = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] alarm_in = '0;
    logic       emergency_in = 1'b0;
    logic       ack_pb = 1'b0;
    logic       reset_pb = 1'b0;
    logic       lamp_test = 1'b0;
    logic [7:0] lamp;
    logic       emergency_lamp;
    logic       horn;
    logic [2:0] first_out;
    logic       first_out_valid;

    int total = 0;
    int bad = 0;

    rpsc_annunciator #(.FAST_HALF(FH)) dut (
        .clk(clk), .reset(reset), .alarm_in(alarm_in), .emergency_in(emergency_in),
        .ack_pb(ack_pb), .reset_pb(reset_pb), .lamp_test(lamp_test), .lamp(lamp),
        .emergency_lamp(emergency_lamp), .horn(horn), .first_out(first_out),
        .first_out_valid(first_out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h at t=%0t", nm, got, exp, $time);
        end
    endtask

    // behavioural model: sampled inputs, channel conditions, cycles since reset
    int       m_st [8];
    int       m_k = 0;
    bit       m_started = 0;
    bit [7:0] m_aq;
    bit       m_eq, m_ackq, m_rstq, m_ltq, m_ackp, m_rstp, m_fov;
    bit [2:0] m_fo;
    bit       m_ack_press, m_rst_press, m_was_all, m_now_all, m_found;

    always @(posedge clk) begin
        if (reset) begin
            for (int n = 0; n < 8; n++) m_st[n] = NORMAL;
            m_k = 0; m_aq = 0; m_eq = 0; m_ackq = 0; m_rstq = 0; m_ltq = 0;
            m_ackp = 1; m_rstp = 1; m_fo = 0; m_fov = 0; m_started = 1;
        end else begin
            m_ack_press = m_ackq && !m_ackp;
            m_rst_press = m_rstq && !m_rstp;
            m_was_all = 1;
            for (int n = 0; n < 8; n++) if (m_st[n] != NORMAL) m_was_all = 0;
            for (int n = 0; n < 8; n++) begin
                if (m_st[n] == NORMAL && m_aq[n]) m_st[n] = ALERT;
                else if (m_st[n] == ALERT && m_ack_press) m_st[n] = m_aq[n] ? ACKED : NORMAL;
                else if (m_st[n] == ACKED && !m_aq[n]) m_st[n] = RTN;
                else if (m_st[n] == RTN) m_st[n] = m_aq[n] ? ALERT : (m_rst_press ? NORMAL : RTN);
            end
            m_now_all = 1;
            for (int n = 0; n < 8; n++) if (m_st[n] != NORMAL) m_now_all = 0;
            m_found = 0;
            if (m_was_all)
                for (int n = 0; n < 8; n++)
                    if (!m_found && m_st[n] == ALERT) begin m_fo = 3'(n); m_fov = 1; m_found = 1; end
            if (m_now_all) begin m_fo = 0; m_fov = 0; end
            m_ackp = (m_k == 0) ? 1'b1 : m_ackq;
            m_rstp = (m_k == 0) ? 1'b1 : m_rstq;
            m_aq = alarm_in; m_eq = emergency_in; m_ackq = ack_pb; m_rstq = reset_pb; m_ltq = lamp_test;
            m_k++;
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            logic [7:0] el;
            logic eh, fast, slow;
            fast = ((m_k / FH) % 2) == 0;
            slow = ((m_k / (4 * FH)) % 2) == 0;
            eh = m_eq;
            for (int n = 0; n < 8; n++) begin
                el[n] = m_ltq ? 1'b1 : (m_st[n] == ALERT) ? fast : (m_st[n] == ACKED) ? 1'b1 :
                        (m_st[n] == RTN) ? slow : 1'b0;
                if (m_st[n] == ALERT) eh = 1'b1;
            end
            chk("model_lamp", lamp, el);
            chk("model_emergency_lamp", {7'd0, emergency_lamp}, {7'd0, m_eq | m_ltq});
            chk("model_horn", {7'd0, horn}, {7'd0, eh});
            chk("model_first_out", {5'd0, first_out}, {5'd0, m_fo});
            chk("model_first_out_valid", {7'd0, first_out_valid}, {7'd0, m_fov});
        end
    end

    task automatic tick(input int c);
        repeat (c) @(negedge clk);
    endtask

    task automatic press_ack();
        ack_pb = 1; tick(1); ack_pb = 0; tick(2);
    endtask

    task automatic press_rst();
        reset_pb = 1; tick(1); reset_pb = 0; tick(2);
    endtask

    task automatic toggles(input int b, input int intervals, output int cnt);
        logic p;
        cnt = 0;
        p = lamp[b];
        repeat (intervals) begin
            tick(1);
            if (lamp[b] !== p) cnt++;
            p = lamp[b];
        end
    endtask

    initial begin
        int c;
        tick(3);
        chk("reset_lamp", lamp, 8'h00);
        chk("reset_horn", {7'd0, horn}, 8'h00);
        chk("reset_valid", {7'd0, first_out_valid}, 8'h00);
        chk("reset_emergency", {7'd0, emergency_lamp}, 8'h00);
        reset = 0; tick(2);
        // single channel alert, flash, acknowledge
        alarm_in = 8'h04; tick(2);
        chk("ch2_first_out", {5'd0, first_out}, 8'd2);
        chk("ch2_valid", {7'd0, first_out_valid}, 8'd1);
        chk("ch2_horn", {7'd0, horn}, 8'd1);
        toggles(2, 16, c);
        chk("fast_toggles_16", 8'(c), 8'd4);
        press_ack();
        chk("acked_lamp", lamp, 8'h04);
        chk("acked_horn", {7'd0, horn}, 8'd0);
        // ringback and reset
        alarm_in = 8'h00; tick(2);
        toggles(2, 32, c);
        chk("slow_toggles_32", 8'(c), 8'd2);
        press_rst();
        chk("rst_lamp", lamp, 8'h00);
        chk("rst_valid", {7'd0, first_out_valid}, 8'd0);
        chk("rst_first_out", {5'd0, first_out}, 8'd0);
        // simultaneous entries, later alarm, long ack hold
        alarm_in = 8'h90; tick(2);
        chk("multi_first_out", {5'd0, first_out}, 8'd4);
        alarm_in = 8'h91; tick(2);
        chk("later_first_out", {5'd0, first_out}, 8'd4);
        ack_pb = 1; tick(40);
        alarm_in = 8'h99; tick(60);
        ack_pb = 0; tick(2);
        chk("hold_acked_lamps", lamp & 8'h91, 8'h91);
        chk("hold_single_action_horn", {7'd0, horn}, 8'd1);
        alarm_in = 8'h00; tick(2);
        press_ack();
        press_rst();
        chk("hold_clear_valid", {7'd0, first_out_valid}, 8'd0);
        // one-cycle pulse stays latched until ack
        alarm_in = 8'h01; tick(1); alarm_in = 8'h00; tick(10);
        chk("pulse_horn", {7'd0, horn}, 8'd1);
        press_ack();
        chk("pulse_ack_lamp0", {7'd0, lamp[0]}, 8'd0);
        chk("pulse_ack_horn", {7'd0, horn}, 8'd0);
        // re-alarm beats simultaneous reset press, lamp test
        alarm_in = 8'h20; tick(2);
        press_ack();
        alarm_in = 8'h00; tick(3);
        alarm_in = 8'h20; reset_pb = 1; tick(1); reset_pb = 0; tick(1);
        chk("realarm_horn", {7'd0, horn}, 8'd1);
        lamp_test = 1; tick(2);
        chk("lt_lamp", lamp, 8'hFF);
        chk("lt_emergency", {7'd0, emergency_lamp}, 8'd1);
        lamp_test = 0; tick(3);
        chk("lt_release_horn", {7'd0, horn}, 8'd1);
        press_ack();
        alarm_in = 8'h00; tick(2);
        press_rst();
        // emergency line
        emergency_in = 1; tick(2);
        chk("emerg_lamp", {7'd0, emergency_lamp}, 8'd1);
        chk("emerg_horn", {7'd0, horn}, 8'd1);
        emergency_in = 0; tick(2);
        chk("emerg_off_horn", {7'd0, horn}, 8'd0);
        // reset mid-alert with ack held
        alarm_in = 8'h02; tick(2);
        ack_pb = 1; reset = 1; tick(1);
        chk("midrst_lamp", lamp, 8'h00);
        chk("midrst_horn", {7'd0, horn}, 8'd0);
        chk("midrst_valid", {7'd0, first_out_valid}, 8'd0);
        reset = 0; tick(1);
        chk("midrst_not_yet", {7'd0, horn}, 8'd0);
        tick(1);
        chk("midrst_realarm", {7'd0, horn}, 8'd1);
        tick(5);
        chk("midrst_no_ack", {7'd0, horn}, 8'd1);
        ack_pb = 0; alarm_in = 8'h00; tick(2);
        press_ack();
        // randomized traffic
        repeat (4000) begin
            if ($urandom_range(0, 7) == 0) alarm_in[$urandom_range(0, 7)] ^= 1'b1;
            if ($urandom_range(0, 5) == 0) ack_pb = ~ack_pb;
            if ($urandom_range(0, 5) == 0) reset_pb = ~reset_pb;
            if ($urandom_range(0, 39) == 0) lamp_test = ~lamp_test;
            if ($urandom_range(0, 39) == 0) emergency_in = ~emergency_in;
            reset = ($urandom_range(0, 599) == 0);
            tick(1);
        end
        reset = 0; tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
